// File: rtl/wind_dir_conditioner.sv
// rtl/wind_dir_conditioner.sv - synchronize, debounce and validate the raw wind-direction switches
module wind_dir_conditioner #(
    parameter int DB_CYCLES = 4
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [1:0] sw_raw,
    output logic [1:0] dir_out,
    output logic       dir_changed,
    output logic       invalid
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);
    localparam logic [1:0] ILLEGAL = 2'b11;

    logic [1:0]    s1;
    logic [1:0]    s2;
    logic [1:0]    cand;
    logic [CW-1:0] cnt;
    logic          accept;

    // Acceptance uses the pre-edge count, so a change of s2 on the saturating edge wins.
    assign accept = (cnt == CNT_MAX) && (s2 == cand);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            s1          <= 2'b00;
            s2          <= 2'b00;
            cand        <= 2'b00;
            cnt         <= '0;
            dir_out     <= 2'b00;
            dir_changed <= 1'b0;
            invalid     <= 1'b0;
        end else begin
            s1          <= sw_raw;
            s2          <= s1;
            dir_changed <= 1'b0;

            if (s2 != cand) begin
                cand <= s2;
                cnt  <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end

            // The illegal code freezes dir_out at its last legal value.
            if (accept) begin
                if (cand == ILLEGAL) begin
                    invalid <= 1'b1;
                end else begin
                    invalid <= 1'b0;
                    if (cand != dir_out) begin
                        dir_out     <= cand;
                        dir_changed <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_wind_dir_conditioner.sv
// tb/tb_wind_dir_conditioner.sv - scoreboard bench for wind_dir_conditioner
module tb_wind_dir_conditioner;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] sw_raw;
    logic [1:0] dir_out;
    logic       dir_changed;
    logic       invalid;

    int checks = 0;
    int passes = 0;

    wind_dir_conditioner #(.DB_CYCLES(DB)) dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .sw_raw      (sw_raw),
        .dir_out     (dir_out),
        .dir_changed (dir_changed),
        .invalid     (invalid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] dir;
        logic       chg;
        logic       inv;
    } exp_t;

    exp_t exp_q[$];

    // Reference: s2 is sw_raw delayed two edges; a value is accepted once it has been
    // seen on s2 for DB+1 consecutive edges (reset counts as the first sample of 00).
    logic [1:0] m_d1, m_d2, run_val, m_dir;
    int         run_len;
    logic       m_inv, m_chg;

    always @(posedge clk) begin
        exp_t e;
        if (reset) begin
            m_d1 = 2'b00; m_d2 = 2'b00;
            run_val = 2'b00; run_len = 1;
            m_dir = 2'b00; m_inv = 1'b0; m_chg = 1'b0;
        end else begin
            if (m_d2 == run_val) run_len = run_len + 1;
            else begin run_val = m_d2; run_len = 1; end
            m_chg = 1'b0;
            if (run_len >= DB + 1) begin
                if (run_val == 2'b11) m_inv = 1'b1;
                else begin
                    m_inv = 1'b0;
                    if (run_val != m_dir) begin m_dir = run_val; m_chg = 1'b1; end
                end
            end
            m_d2 = m_d1;
            m_d1 = sw_raw;
        end
        e.dir = m_dir; e.chg = m_chg; e.inv = m_inv;
        exp_q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({dir_out, dir_changed, invalid} === e) passes++;
            else $display("FAIL scoreboard t=%0t dir/chg/inv actual=%b/%b/%b required=%b/%b/%b",
                          $time, dir_out, dir_changed, invalid, e.dir, e.chg, e.inv);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s actual=%b required=%b", name, act, req);
    endtask

    function automatic logic [3:0] outs();
        return {dir_out, dir_changed, invalid};
    endfunction

    initial begin
        reset  = 1'b1;
        sw_raw = 2'b00;
        repeat (3) tick();
        chk("reset_state", outs(), 4'b0000);
        reset = 1'b0;
        repeat (6) tick();

        // Short glitch must not be accepted.
        sw_raw = 2'b01;
        repeat (3) tick();
        sw_raw = 2'b00;
        repeat (10) tick();
        chk("glitch_rejected", outs(), 4'b0000);

        // Basic latency: accepted on edge DB+3.
        sw_raw = 2'b01;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == DB + 2) chk("latency_edge6", outs(), 4'b0000);
            if (k == DB + 3) chk("latency_edge7", outs(), 4'b0110);
            if (k == DB + 4) chk("pulse_single", outs(), 4'b0100);
        end
        repeat (4) tick();

        // Illegal code holds direction and raises invalid.
        sw_raw = 2'b11;
        for (int k = 1; k <= DB + 3; k++) tick();
        chk("invalid_set", outs(), 4'b0101);
        repeat (4) tick();
        sw_raw = 2'b10;
        for (int k = 1; k <= DB + 3; k++) tick();
        chk("invalid_clear", outs(), 4'b1010);
        repeat (4) tick();

        // Direct legal-to-legal transition.
        sw_raw = 2'b01;
        repeat (12) tick();
        chk("direct_01", outs(), 4'b0100);
        sw_raw = 2'b10;
        repeat (12) tick();
        chk("direct_10", outs(), 4'b1000);

        // Reset mid-debounce restarts the full latency.
        sw_raw = 2'b01;
        repeat (12) tick();
        sw_raw = 2'b10;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset_mid_debounce", outs(), 4'b0000);
        for (int k = 1; k <= DB + 3; k++) begin
            tick();
            if (k == DB + 2) chk("post_reset_edge6", outs(), 4'b0000);
        end
        chk("post_reset_edge7", outs(), 4'b1010);

        // Toggle every cycle, then rest at 00.
        sw_raw = 2'b00;
        repeat (12) tick();
        for (int k = 0; k < 20; k++) begin
            sw_raw = (k % 2 == 0) ? 2'b01 : 2'b00;
            tick();
        end
        sw_raw = 2'b00;
        repeat (10) tick();
        chk("toggle_rest", outs(), 4'b0000);

        // Randomized segments with occasional reset.
        for (int s = 0; s < 300; s++) begin
            int len;
            sw_raw = 2'($urandom_range(0, 3));
            len = $urandom_range(1, 9);
            for (int k = 0; k < len; k++) begin
                reset = ($urandom_range(0, 59) == 0);
                tick();
            end
            reset = 1'b0;
        end

        repeat (3) tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/wind_dir_conditioner.md
WIND_DIR_CONDITIONER -- requirements
Module: wind_dir_conditioner

Purpose: upstream stage of the hazard-light FSM. Synchronizes and debounces the raw wind-direction switches, rejects the illegal code, and presents a clean 2-bit direction plus a one-cycle change pulse that restarts the light pattern.

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 4, meaning consecutive stable synchronized cycles required before acceptance; legal range 2..255.
REQ-002 SHALL have port CLOCK_50, input, 1 bit: the single clock for the block; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port sw_raw, input, 2 bits: asynchronous raw switch code from SW[1:0].
REQ-005 SHALL have port dir_out, output, 2 bits: debounced direction.
- 00: calm
- 01: right-to-left
- 10: left-to-right
REQ-006 SHALL have port dir_changed, output, 1 bit: one-cycle pulse when dir_out takes a new value.
REQ-007 SHALL have port invalid, output, 1 bit: level, high while the debounced input is the illegal code 11.

Function
REQ-008 SHALL pass sw_raw through a two-flop synchronizer (s1, then s2) before any other use; no logic SHALL read sw_raw directly.
REQ-009 SHALL hold a candidate register cand[1:0] and a counter cnt of width clog2(DB_CYCLES).
REQ-010 Each edge, s2 != cand: SHALL load cand <= s2 and cnt <= 0.
REQ-011 Each edge, s2 == cand and cnt < DB_CYCLES-1: SHALL increment cnt by 1.
REQ-012 Once cnt == DB_CYCLES-1: SHALL hold cnt saturated; it SHALL never wrap.
REQ-013 Acceptance condition is cnt == DB_CYCLES-1 and s2 == cand.
REQ-014 On acceptance with cand != 11 and cand != dir_out: SHALL load dir_out <= cand and assert dir_changed for exactly the next cycle.
REQ-015 On acceptance with cand == dir_out: SHALL leave dir_out unchanged and keep dir_changed low.
REQ-016 On acceptance with cand == 11: SHALL set invalid to 1, hold dir_out at its last legal value, and keep dir_changed low.
REQ-017 On acceptance with cand != 11: SHALL clear invalid to 0, in the same edge as any dir_out update.
REQ-018 dir_changed SHALL be high for one cycle only, even while the accepted condition persists; it re-arms only after a different value is accepted.
REQ-019 Latency: sw_raw changes and then holds. The first rising edge after the change counts as edge 1. dir_out SHALL update and dir_changed SHALL rise on edge DB_CYCLES+3, which is edge 7 at the default.
REQ-020 Glitch rejection: any synchronized change lasting fewer than DB_CYCLES consecutive cycles SHALL leave dir_out, dir_changed and invalid unaffected.
REQ-021 A change of s2 on the same edge that cnt would saturate SHALL take priority (REQ-010); no acceptance occurs on that edge.
REQ-022 A direct legal-to-legal transition (01 to 10) SHALL produce one dir_changed pulse and no intermediate 00 on dir_out.
REQ-023 All outputs SHALL be registered; no combinational path from sw_raw to any output.

Reset
REQ-024 When reset is high at a rising edge, SHALL set s1, s2, cand and dir_out to 00, cnt to 0, dir_changed to 0 and invalid to 0.
REQ-025 Reset SHALL dominate all other updates, including a pending acceptance in the same edge.
REQ-026 Reset asserted mid-debounce SHALL discard partial progress; after release, the full REQ-019 latency SHALL apply from the first post-reset edge.
REQ-027 Reset SHALL not itself generate a dir_changed pulse, before or after release.

Verification (DB_CYCLES=4)
REQ-028 Reset, then sw_raw 00->01 held -> dir_out=01 and dir_changed=1 on edge 7 only; dir_changed=0 on edge 8 onward.
REQ-029 sw_raw=01 pulse for 3 cycles, then back to 00 -> dir_out stays 00; dir_changed never asserts.
REQ-030 dir_out=01 stable, sw_raw->11 held -> invalid=1 on edge 7, dir_out stays 01, no pulse; then sw_raw->10 held -> dir_out=10, invalid=0 and one pulse on edge 7 of that change.
REQ-031 dir_out=01, sw_raw->10 held -> dir_out goes 01->10 directly, exactly one pulse, never 00.
REQ-032 sw_raw->10, reset asserted on edge 5 for one cycle, sw_raw held -> all outputs 00/0 after reset; dir_out=10 on edge 7 counted from the first edge after reset release.
REQ-033 sw_raw toggles 00/01 every cycle for 20 cycles, then rests at 00 -> dir_out=00, invalid=0, no pulse throughout.
